dmem_banked_ctrl: RTL

- Parametrised successor to the single-cycle word data memory used by the datapath MEM stage.
- Byte-addressed, little-endian, 32-bit data memory with byte/half/word loads and stores and sign/zero extension on loads.
- Configurable wait-state count and a request/ready/valid handshake, so the pipeline can stall on slow memory.
- Sits between the MEM-stage control and the hazard/stall unit.

---
 rtl/dmem_banked_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dmem_banked_ctrl.sv
// dmem_banked_ctrl: byte-addressed little-endian 32-bit data memory with a
// request/ready/valid handshake and WAIT_CYCLES extra wait states per access.
// Byte/half/word loads and stores; loads are sign- or zero-extended.
// Optional build macro DMEM_ALIGN_CHECK_EN adds the Error port. With it,
// misaligned or out-of-range accesses fault: the store is suppressed, the
// load returns 0, and Error pulses.
//
// state   | meaning
// IDLE    | Ready=1, waiting for a qualified request
// WAITING | wait states, counting waitCnt down to 0
// ACCESS  | commit the store or register the load data on the exit edge
module dmem_banked_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  output logic              Ready,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              ReadValid
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              Error
`endif
);

  localparam int IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAITING, ACCESS} stateT;

  stateT             state;
  logic [3:0]        waitCnt;
  logic [IdxW+1:0]   latAddr;
  logic [31:0]       latWData;
  logic [1:0]        latSize;
  logic              latUns;
  logic              latStore;

  logic [31:0]       mem [DEPTH];
  logic [IdxW-1:0]   wordIdx;
  logic [1:0]        byteOff;
  logic [31:0]       rdWord;
  logic [31:0]       shifted;
  logic [31:0]       loadVal;
  logic [31:0]       wShift;
  logic [3:0]        byteEn;
  logic              fault;
  logic              commit;

`ifdef DMEM_ALIGN_CHECK_EN
  logic latHigh;
  logic misaligned;
  assign misaligned = (latSize == 2'b01 && latAddr[0]) ||
                      (latSize[1] && latAddr[1:0] != 2'b00);
  assign fault = misaligned || latHigh;
`else
  // Upper address bits only matter for range checking; without it they wrap.
  logic unusedAddrBits;
  assign unusedAddrBits = ^Address[ADDR_W-1:IdxW+2];
  assign fault = 1'b0;
`endif

  assign wordIdx = latAddr[IdxW+1:2];
  assign rdWord  = mem[wordIdx];
  assign commit  = (state == ACCESS) && latStore && !fault;

  // Align down the lane offset, extract/extend load data, build store lanes.
  always_comb begin
    byteOff = 2'b00;
    byteEn  = 4'b1111;
    case (latSize)
      2'b00: begin
        byteOff = latAddr[1:0];
        byteEn  = 4'b0001 << latAddr[1:0];
      end
      2'b01: begin
        byteOff = {latAddr[1], 1'b0};
        byteEn  = latAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        byteOff = 2'b00;
        byteEn  = 4'b1111;
      end
    endcase
    shifted = rdWord >> {byteOff, 3'b000};
    wShift  = latWData << {byteOff, 3'b000};
    case (latSize)
      2'b00:   loadVal = latUns ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   loadVal = latUns ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: loadVal = shifted;
    endcase
  end

  // Storage array; not reset, written only on the ACCESS exit edge.
  always_ff @(posedge Clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wShift[8*b +: 8];
      end
    end
  end

  // Control FSM with registered handshake outputs and load data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      latAddr   <= '0;
      latWData  <= 32'h0;
      latSize   <= 2'b00;
      latUns    <= 1'b0;
      latStore  <= 1'b0;
      Ready     <= 1'b1;
      ReadValid <= 1'b0;
      ReadData  <= 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
      latHigh   <= 1'b0;
      Error     <= 1'b0;
`endif
    end else begin
      ReadValid <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      Error     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Req && (MemRead || MemWrite)) begin
            latAddr  <= Address[IdxW+1:0];
            latWData <= WriteData;
            latSize  <= Size;
            latUns   <= Unsigned;
            latStore <= MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
            latHigh  <= |Address[ADDR_W-1:IdxW+2];
`endif
            Ready    <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state   <= WAITING;
              waitCnt <= 4'(WAIT_CYCLES - 1);
            end else begin
              state   <= ACCESS;
            end
          end
        end
        WAITING: begin
          if (waitCnt == 4'd0) state <= ACCESS;
          else                 waitCnt <= waitCnt - 4'd1;
        end
        ACCESS: begin
          state <= IDLE;
          Ready <= 1'b1;
          if (!latStore) begin
            ReadValid <= 1'b1;
            ReadData  <= fault ? 32'h0 : loadVal;
          end
`ifdef DMEM_ALIGN_CHECK_EN
          Error <= fault;
`endif
        end
        default: begin
          state <= IDLE;
          Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
